// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared MIPS constants and helpers. The fetch stage, the
//                decode Controller and EX use these definitions so that
//                they all compute the same pseudo-direct jump target and
//                agree on the bubble encoding.
//  Contents    : NOP_INS, opcode/funct constants, pseudo_direct_target()
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Encoding placed in IF/ID when a bubble is inserted (sll $0,$0,0).
  localparam logic [31:0] NOP_INS  = 32'h0000_0000;

  localparam logic [5:0]  OP_J     = 6'h02;
  localparam logic [5:0]  OP_JAL   = 6'h03;
  localparam logic [5:0]  OP_LW    = 6'h23;
  localparam logic [5:0]  FUNCT_JR = 6'h08;

  // j/jal target: upper nibble of the delay-free PC+4, the 26-bit
  // instruction index, and a word-aligning 2'b00.
  function automatic logic [31:0] pseudo_direct_target(
    input logic [3:0]  pc4_hi,
    input logic [25:0] instr_index
  );
    return {pc4_hi, instr_index, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Event counter that sticks at all-ones. A clear request in
//                the same cycle as an increment wins.
//  Ports       : clk    in   clock
//                rst_n  in   asynchronous active-low reset
//                inc    in   count one event
//                clr    in   synchronous clear to zero
//                count  out  CNT_W-bit count value
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : MIPS instruction fetch with the IF/ID pipeline register.
//                Owns the PC, applies the Controller's stall/redirect for
//                the instruction in ID, and adds a run/halt/single-step
//                FSM plus saturating stall/flush counters for debug.
//  Ports       : clk, rst_n             clock, async active-low reset
//                imem_addr / imem_rdata combinational instruction memory
//                stall, jump_out,       Controller controls for the ID
//                j_jump, jr_target      instruction and the jr target
//                run_en, step           free-run enable / step pulse
//                cnt_clr                clear both event counters
//                pc, if_id_*            PC and IF/ID register contents
//                halted                 FSM is in HALT
//                stall_cnt, flush_cnt   bubble / redirect counts
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             stall,
  input  logic             jump_out,
  input  logic             j_jump,
  input  logic [31:0]      jr_target,
  input  logic             run_en,
  input  logic             step,
  input  logic             cnt_clr,
  output logic [31:0]      pc,
  output logic [31:0]      if_id_ins,
  output logic [31:0]      if_id_pc4,
  output logic             if_id_valid,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        advance;
  logic        ctl_jump;
  logic        ctl_stall;
  logic        stall_inc;
  logic        flush_inc;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;

  always_comb begin
    pc_plus4    = pc_q + 32'd4;
    // A bubble in ID must never stall or redirect; this also guarantees
    // that a combinational stall from the Controller releases after one
    // bubble.
    ctl_jump    = jump_out & valid_q;
    ctl_stall   = stall & valid_q;
    advance     = (state_q == ST_RUN) ? run_en : step;
    jump_target = j_jump ? pseudo_direct_target(pc4_q[31:28], ins_q[25:0])
                         : jr_target;

    state_d = state_q;
    if (state_q == ST_RUN) begin
      if (!run_en) state_d = ST_HALT;
    end else begin
      if (run_en) state_d = ST_RUN;
    end

    pc_d      = pc_q;
    ins_d     = ins_q;
    pc4_d     = pc4_q;
    valid_d   = valid_q;
    stall_inc = 1'b0;
    flush_inc = 1'b0;

    if (advance) begin
      if (ctl_jump) begin
        // No delay slot: the word fetched this cycle is dropped.
        pc_d      = jump_target;
        ins_d     = NOP_INS;
        pc4_d     = 32'h0;
        valid_d   = 1'b0;
        flush_inc = 1'b1;
      end else if (ctl_stall) begin
        // PC holds so the same word is fetched again next cycle.
        ins_d     = NOP_INS;
        pc4_d     = 32'h0;
        valid_d   = 1'b0;
        stall_inc = 1'b1;
      end else begin
        ins_d     = imem_rdata;
        pc4_d     = pc_plus4;
        valid_d   = 1'b1;
        pc_d      = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      ins_q   <= NOP_INS;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .clr   (cnt_clr),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .clr   (cnt_clr),
    .count (flush_cnt)
  );

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign if_id_ins   = ins_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign halted      = (state_q == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage. A behavioural model
//                tracks the expected architectural state; a compare process
//                checks every output after each clock edge, and the directed
//                sequence adds hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  // Narrow counters keep the saturation scenario short.
  localparam int          TB_CNT_W = 8;
  localparam int          CNT_MAX  = (1 << TB_CNT_W) - 1;
  localparam logic [31:0] INS_ADDI = 32'h2008_0001;
  localparam logic [31:0] INS_LW   = 32'h8C09_0000;
  localparam logic [31:0] INS_JAL  = 32'h0C00_0010;

  logic                clk;
  logic                rst_n;
  logic [31:0]         imem_addr;
  logic [31:0]         imem_rdata;
  logic                stall, jump_out, j_jump;
  logic [31:0]         jr_target;
  logic                run_en, step, cnt_clr;
  logic [31:0]         pc, if_id_ins, if_id_pc4;
  logic                if_id_valid, halted;
  logic [TB_CNT_W-1:0] stall_cnt, flush_cnt;

  logic [31:0] rom [0:255];
  assign imem_rdata = rom[imem_addr[9:2]];

  fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(TB_CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .jump_out    (jump_out),
    .j_jump      (j_jump),
    .jr_target   (jr_target),
    .run_en      (run_en),
    .step        (step),
    .cnt_clr     (cnt_clr),
    .pc          (pc),
    .if_id_ins   (if_id_ins),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .halted      (halted),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_ins, m_pc4;
  logic        m_valid, m_halt;
  int          m_stall, m_flush;
  logic        m_go;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_ins = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_halt = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      m_go = m_halt ? step : run_en;
      if (m_go && m_valid && jump_out) begin
        m_pc    = j_jump ? {m_pc4[31:28], m_ins[25:0], 2'b00} : jr_target;
        m_ins   = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        m_flush = (m_flush >= CNT_MAX) ? CNT_MAX : m_flush + 1;
      end else if (m_go && m_valid && stall) begin
        m_ins   = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        m_stall = (m_stall >= CNT_MAX) ? CNT_MAX : m_stall + 1;
      end else if (m_go) begin
        m_ins   = rom[m_pc[9:2]];
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
      end
      if (cnt_clr) begin
        m_stall = 0;
        m_flush = 0;
      end
      // Whatever the current state, the state after this edge is HALT
      // exactly when run_en was low.
      m_halt = !run_en;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("pc",        pc,                 m_pc);
      chk("imem_addr", imem_addr,          m_pc);
      chk("if_id_ins", if_id_ins,          m_ins);
      chk("if_id_pc4", if_id_pc4,          m_pc4);
      chk("valid",     32'(if_id_valid),   32'(m_valid));
      chk("halted",    32'(halted),        32'(m_halt));
      chk("stall_cnt", 32'(stall_cnt),     32'(m_stall));
      chk("flush_cnt", 32'(flush_cnt),     32'(m_flush));
    end
  end

  task automatic edge_n(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = INS_ADDI;
    rom[1] = INS_JAL;
    rom[3] = INS_LW;
    rst_n = 1'b0; run_en = 1'b1; step = 1'b0; stall = 1'b0;
    jump_out = 1'b0; j_jump = 1'b0; jr_target = 32'h0; cnt_clr = 1'b0;

    // Reset state
    #12;
    chk("rst_pc",    pc,                32'h0);
    chk("rst_valid", 32'(if_id_valid),  32'h0);
    chk("rst_ins",   if_id_ins,         32'h0);
    chk("rst_halt",  32'(halted),       32'h0);
    chk("rst_scnt",  32'(stall_cnt),    32'h0);
    chk("rst_fcnt",  32'(flush_cnt),    32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Straight-line fetch
    edge_n(1);
    chk("t1_pc4",   pc,               32'h4);
    chk("t1_ins",   if_id_ins,        INS_ADDI);
    chk("t1_ipc4",  if_id_pc4,        32'h4);
    chk("t1_valid", 32'(if_id_valid), 32'h1);
    edge_n(1);
    chk("t1_pc8",   pc,               32'h8);
    edge_n(2);
    chk("t2_pc10",  pc,               32'h10);
    chk("t2_lw",    if_id_ins,        INS_LW);

    // lw stall: one bubble, then refetch of 0x10
    @(negedge clk); stall = 1'b1;
    edge_n(1);
    chk("t2_hold",  pc,               32'h10);
    chk("t2_bub",   32'(if_id_valid), 32'h0);
    chk("t2_bins",  if_id_ins,        32'h0);
    chk("t2_scnt",  32'(stall_cnt),   32'h1);
    @(negedge clk); stall = 1'b0;
    edge_n(1);
    chk("t2_refpc", pc,               32'h14);
    chk("t2_refp4", if_id_pc4,        32'h14);

    // jal redirect
    do_reset();
    edge_n(2);
    chk("t3_jal",   if_id_ins,        INS_JAL);
    chk("t3_link",  if_id_pc4,        32'h8);
    @(negedge clk); jump_out = 1'b1; j_jump = 1'b1;
    edge_n(1);
    chk("t3_tgt",   pc,               32'h40);
    chk("t3_bub",   32'(if_id_valid), 32'h0);
    chk("t3_fcnt",  32'(flush_cnt),   32'h1);
    @(negedge clk); jump_out = 1'b0; j_jump = 1'b0;

    // jr with simultaneous stall: jump wins
    edge_n(1);
    chk("t4_pc44",  pc,               32'h44);
    @(negedge clk); jump_out = 1'b1; jr_target = 32'h200; stall = 1'b1;
    edge_n(1);
    chk("t4_tgt",   pc,               32'h200);
    chk("t4_fcnt",  32'(flush_cnt),   32'h2);
    chk("t4_scnt",  32'(stall_cnt),   32'h0);
    // Bubble in ID ignores stall; jr_target ignored outside redirect
    @(negedge clk); jump_out = 1'b0; jr_target = 32'hDEAD_BEEF;
    edge_n(1);
    chk("t4_nostl", pc,               32'h204);
    @(negedge clk); stall = 1'b0; jump_out = 1'b1; jr_target = 32'hFFFF_FFFC;
    edge_n(1);
    chk("t4_top",   pc,               32'hFFFF_FFFC);
    @(negedge clk); jump_out = 1'b0;
    edge_n(1);
    chk("t4_wrap",  pc,               32'h0);
    chk("t4_wrp4",  if_id_pc4,        32'h0);

    // Halt / step
    do_reset();
    edge_n(8);
    chk("t5_pc20",  pc,               32'h20);
    @(negedge clk); run_en = 1'b0;
    edge_n(1);
    chk("t5_halt",  32'(halted),      32'h1);
    chk("t5_frz",   pc,               32'h20);
    edge_n(5);
    chk("t5_frz5",  pc,               32'h20);
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    chk("t5_step",  pc,               32'h24);
    edge_n(3);
    chk("t5_once",  pc,               32'h24);
    @(negedge clk); step = 1'b1;
    edge_n(2);
    chk("t5_held",  pc,               32'h2C);
    @(negedge clk); step = 1'b0; run_en = 1'b1;
    edge_n(1);
    chk("t5_run",   32'(halted),      32'h0);
    chk("t5_nadv",  pc,               32'h2C);
    edge_n(1);
    chk("t5_res",   pc,               32'h30);

    // Counter saturation and clear
    @(negedge clk); stall = 1'b1;
    edge_n(2 * CNT_MAX + 10);
    chk("t6_sat",   32'(stall_cnt),   32'(CNT_MAX));
    if (!m_valid) edge_n(1);
    @(negedge clk); cnt_clr = 1'b1;
    edge_n(1);
    chk("t6_clr",   32'(stall_cnt),   32'h0);
    @(negedge clk); cnt_clr = 1'b0; stall = 1'b0;

    // Asynchronous reset in mid-cycle
    do_reset();
    edge_n(32);
    chk("t6_pc80",  pc,               32'h80);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_apc",   pc,               32'h0);
    chk("t6_aval",  32'(if_id_valid), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    edge_n(1);
    chk("t6_first", if_id_pc4,        32'h4);
    chk("t6_fins",  if_id_ins,        INS_ADDI);

    edge_n(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
